// File: rtl/multicycle_datapath_pkg.sv
// Shared encodings for the multi-cycle ARM-subset datapath and its controller:
// ALU op codes, operand/result/immediate selects, flag layout and the immediate extender.
package multicycle_datapath_pkg;

  localparam int DW = 32;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_MOV = 4'b0101;

  localparam logic [1:0] SRCA_A      = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;
  localparam logic [1:0] SRCA_ZERO   = 2'b11;

  localparam logic [1:0] SRCB_WD     = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic [1:0] SRCB_ZERO   = 2'b11;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;
  localparam logic [1:0] RES_ZERO    = 2'b11;

  localparam logic [1:0] IMM_8       = 2'b00;
  localparam logic [1:0] IMM_12      = 2'b01;
  localparam logic [1:0] IMM_BR      = 2'b10;
  localparam logic [1:0] IMM_ZERO    = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] REG_PC = 4'd15;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  // Branch offsets are word counts, hence the sign extension followed by a 2-bit shift.
  function automatic logic [DW-1:0] extend(input logic [23:0] imm, input logic [1:0] immSrc);
    logic [DW-1:0] ext;
    ext = '0;
    case (immSrc)
      IMM_8:   ext = {24'b0, imm[7:0]};
      IMM_12:  ext = {20'b0, imm[11:0]};
      IMM_BR:  ext = {{6{imm[23]}}, imm, 2'b00};
      default: ext = '0;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/multicycle_datapath_if.sv
// Controller/memory-facing bundle of the datapath: control strobes and selects in,
// memory address/data and instruction/flag feedback out.
interface multicycle_datapath_if;
  import multicycle_datapath_pkg::*;

  logic          PCWrite;
  logic          AdrSrc;
  logic          IRWrite;
  logic          RegWrite;
  logic [1:0]    RegSrc;
  logic [1:0]    ALUSrcA;
  logic [1:0]    ALUSrcB;
  logic [1:0]    ResultSrc;
  logic [1:0]    ImmSrc;
  logic [3:0]    ALUControl;
  logic [DW-1:0] ReadData;
  logic [DW-1:0] Adr;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] Instr;
  logic [3:0]    ALUFlags;

  modport master (
    output PCWrite, AdrSrc, IRWrite, RegWrite, RegSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, ALUControl, ReadData,
    input  Adr, WriteData, Instr, ALUFlags
  );

  modport slave (
    input  PCWrite, AdrSrc, IRWrite, RegWrite, RegSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, ALUControl, ReadData,
    output Adr, WriteData, Instr, ALUFlags
  );

endinterface

// File: rtl/multicycle_datapath_regfile.sv
// R0-R14 storage with two combinational reads and one synchronous write.
// Index 15 is not stored: reads return the r15_i bypass and writes are dropped.
module multicycle_datapath_regfile
  import multicycle_datapath_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [3:0]    wa_i,
  input  logic [DW-1:0] wd_i,
  input  logic [3:0]    ra1_i,
  input  logic [3:0]    ra2_i,
  input  logic [DW-1:0] r15_i,
  output logic [DW-1:0] rd1_o,
  output logic [DW-1:0] rd2_o
);

  logic [DW-1:0] regs_q [0:14];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (wa_i != REG_PC)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign rd1_o = (ra1_i == REG_PC) ? r15_i : regs_q[ra1_i];
  assign rd2_o = (ra2_i == REG_PC) ? r15_i : regs_q[ra2_i];

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle ARM-subset datapath: PC, IR and staging registers, register file,
// extender and ALU, all sequenced by an external controller through the bus interface.
module multicycle_datapath
  import multicycle_datapath_pkg::*;
#(
  parameter logic [DW-1:0] RESET_PC = 32'h0000_0000
)
(
  input  logic                 clk,
  input  logic                 reset,
  multicycle_datapath_if.slave bus
);

  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] data_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] writeData_q;
  logic [DW-1:0] aluOut_q;

  logic [DW-1:0] rd1, rd2;
  logic [DW-1:0] result;
  logic [DW-1:0] srcA, srcB;
  logic [DW-1:0] extImm;
  logic [DW-1:0] aluResult;
  logic [DW:0]   sum;
  logic [3:0]    ra1, ra2;
  alu_flags_t    flags;

  assign pc_d = bus.PCWrite ? result : pc_q;
  assign ir_d = bus.IRWrite ? bus.ReadData : ir_q;

  // Data, A, WriteData and ALUOut are plain pipeline stages reloaded on every edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      data_q      <= '0;
      a_q         <= '0;
      writeData_q <= '0;
      aluOut_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      data_q      <= bus.ReadData;
      a_q         <= rd1;
      writeData_q <= rd2;
      aluOut_q    <= aluResult;
    end
  end

  assign ra1    = bus.RegSrc[0] ? REG_PC : ir_q[19:16];
  assign ra2    = bus.RegSrc[1] ? ir_q[15:12] : ir_q[3:0];
  assign extImm = extend(ir_q[23:0], bus.ImmSrc);

  multicycle_datapath_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we_i  (bus.RegWrite),
    .wa_i  (ir_q[15:12]),
    .wd_i  (result),
    .ra1_i (ra1),
    .ra2_i (ra2),
    .r15_i (result),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  always_comb begin
    srcA = '0;
    case (bus.ALUSrcA)
      SRCA_A:      srcA = a_q;
      SRCA_PC:     srcA = pc_q;
      SRCA_ALUOUT: srcA = aluOut_q;
      default:     srcA = '0;
    endcase
  end

  always_comb begin
    srcB = '0;
    case (bus.ALUSrcB)
      SRCB_WD:   srcB = writeData_q;
      SRCB_IMM:  srcB = extImm;
      SRCB_FOUR: srcB = 32'd4;
      default:   srcB = '0;
    endcase
  end

  // Subtraction reuses the adder as A + ~B + 1, so C=1 means no borrow.
  always_comb begin
    sum       = '0;
    aluResult = '0;
    flags     = '0;
    case (bus.ALUControl)
      ALU_ADD: begin
        sum       = {1'b0, srcA} + {1'b0, srcB};
        aluResult = sum[DW-1:0];
        flags.c   = sum[DW];
        flags.v   = (srcA[DW-1] == srcB[DW-1]) && (sum[DW-1] != srcA[DW-1]);
      end
      ALU_SUB: begin
        sum       = {1'b0, srcA} + {1'b0, ~srcB} + {{DW{1'b0}}, 1'b1};
        aluResult = sum[DW-1:0];
        flags.c   = sum[DW];
        flags.v   = (srcA[DW-1] != srcB[DW-1]) && (sum[DW-1] != srcA[DW-1]);
      end
      ALU_AND: aluResult = srcA & srcB;
      ALU_ORR: aluResult = srcA | srcB;
      ALU_EOR: aluResult = srcA ^ srcB;
      ALU_MOV: aluResult = srcB;
      default: aluResult = '0;
    endcase
    flags.n = aluResult[DW-1];
    flags.z = (aluResult == '0);
  end

  always_comb begin
    result = '0;
    case (bus.ResultSrc)
      RES_ALUOUT: result = aluOut_q;
      RES_DATA:   result = data_q;
      RES_ALU:    result = aluResult;
      default:    result = '0;
    endcase
  end

  assign bus.Adr       = bus.AdrSrc ? result : pc_q;
  assign bus.WriteData = writeData_q;
  assign bus.Instr     = ir_q;
  assign bus.ALUFlags  = flags;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: hand-sequenced controller strobes with
// hand-computed expectations observed on Adr, WriteData, Instr and ALUFlags.
module tb_multicycle_datapath;
  import multicycle_datapath_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   totalCount = 0;
  int   badCount   = 0;

  multicycle_datapath_if bus();

  multicycle_datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [3:0]  opTab   [6] = '{ALU_AND, ALU_ORR, ALU_EOR, ALU_MOV, 4'b0110, 4'b1111};
  logic [31:0] resTab  [6] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFE,
                               32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
  logic [3:0]  flagTab [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCount++;
    if (got !== exp) begin
      badCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic pcw, input logic adrs, input logic irw, input logic rw,
                               input logic [1:0] regSrc, input logic [1:0] srcA,
                               input logic [1:0] srcB, input logic [1:0] resSrc,
                               input logic [1:0] immSrc, input logic [3:0] aluCtl,
                               input logic [31:0] rdata);
    bus.PCWrite    = pcw;
    bus.AdrSrc     = adrs;
    bus.IRWrite    = irw;
    bus.RegWrite   = rw;
    bus.RegSrc     = regSrc;
    bus.ALUSrcA    = srcA;
    bus.ALUSrcB    = srcB;
    bus.ResultSrc  = resSrc;
    bus.ImmSrc     = immSrc;
    bus.ALUControl = aluCtl;
    bus.ReadData   = rdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0,0,0,0, 2'b00,2'b11,2'b11,2'b00,2'b00, ALU_ADD, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;

    // Post-reset state, then fetch of ADD R1,R1,#5
    applyStimulus(0,0,0,0, 2'b00,2'b11,2'b11,2'b00,2'b00, ALU_ADD, 32'h0);
    checkOutput("reset_pc", bus.Adr, 32'h0);
    checkOutput("reset_instr", bus.Instr, 32'h0);
    checkOutput("flags_zero", {28'b0, bus.ALUFlags}, 32'h4);
    tick();
    applyStimulus(1,0,1,0, 2'b00,2'b01,2'b10,2'b10,2'b00, ALU_ADD, 32'hE281_1005);
    checkOutput("fetch_adr", bus.Adr, 32'h0);
    tick();
    checkOutput("fetch_instr", bus.Instr, 32'hE281_1005);

    // Decode reading R15 through RA1 must see PC+8
    applyStimulus(0,1,0,0, 2'b01,2'b01,2'b10,2'b10,2'b00, ALU_ADD, 32'h0);
    checkOutput("decode_result", bus.Adr, 32'h8);
    tick();
    applyStimulus(0,1,0,0, 2'b00,2'b00,2'b11,2'b10,2'b00, ALU_ADD, 32'h0);
    checkOutput("rd1_r15", bus.Adr, 32'h8);
    tick();

    // R1 <= 7 through the Data register; the same-cycle read of R1 returns the old 0
    applyStimulus(0,0,0,0, 2'b00,2'b11,2'b11,2'b00,2'b00, ALU_ADD, 32'h7);
    checkOutput("pc_after_fetch", bus.Adr, 32'h4);
    tick();
    applyStimulus(0,1,0,1, 2'b00,2'b11,2'b11,2'b01,2'b00, ALU_ADD, 32'h0);
    checkOutput("data_path", bus.Adr, 32'h7);
    tick();
    applyStimulus(0,1,0,0, 2'b00,2'b00,2'b11,2'b10,2'b00, ALU_ADD, 32'h0);
    checkOutput("rf_read_old", bus.Adr, 32'h0);
    tick();

    // Decode, execute ADD R1,R1,#5, write back
    applyStimulus(0,1,0,0, 2'b00,2'b01,2'b10,2'b10,2'b00, ALU_ADD, 32'h0);
    tick();
    applyStimulus(0,1,0,0, 2'b00,2'b00,2'b01,2'b10,2'b00, ALU_ADD, 32'h0);
    checkOutput("add_result", bus.Adr, 32'd12);
    checkOutput("add_flags", {28'b0, bus.ALUFlags}, 32'h0);
    tick();
    applyStimulus(0,1,0,1, 2'b00,2'b11,2'b11,2'b00,2'b00, ALU_ADD, 32'h0);
    checkOutput("aluout_wb", bus.Adr, 32'd12);
    tick();
    applyStimulus(0,0,0,0, 2'b00,2'b11,2'b11,2'b00,2'b00, ALU_ADD, 32'h0);
    tick();
    applyStimulus(0,1,0,0, 2'b00,2'b00,2'b11,2'b10,2'b00, ALU_ADD, 32'h0);
    checkOutput("r1_after_wb", bus.Adr, 32'd12);
    tick();

    // SUB 5-5
    applyStimulus(0,0,0,0, 2'b00,2'b11,2'b01,2'b00,2'b00, ALU_ADD, 32'h0);
    tick();
    applyStimulus(0,0,0,0, 2'b00,2'b10,2'b01,2'b10,2'b00, ALU_SUB, 32'h0);
    checkOutput("sub_eq_flags", {28'b0, bus.ALUFlags}, 32'h6);
    tick();

    // Load ADD R2,R2,#1 into IR only
    applyStimulus(0,0,1,0, 2'b00,2'b11,2'b11,2'b00,2'b00, ALU_ADD, 32'hE282_2001);
    tick();
    checkOutput("ir_load2", bus.Instr, 32'hE282_2001);
    applyStimulus(0,0,0,0, 2'b00,2'b11,2'b01,2'b10,2'b00, ALU_SUB, 32'h0);
    checkOutput("sub_neg_flags", {28'b0, bus.ALUFlags}, 32'h8);
    tick();

    // R2 <= 0x7FFFFFFF, then A <= R2 and WriteData <= R1
    applyStimulus(0,0,0,0, 2'b00,2'b11,2'b11,2'b00,2'b00, ALU_ADD, 32'h7FFF_FFFF);
    tick();
    applyStimulus(0,0,0,1, 2'b00,2'b11,2'b11,2'b01,2'b00, ALU_ADD, 32'h0);
    tick();
    applyStimulus(0,0,0,0, 2'b00,2'b11,2'b11,2'b00,2'b00, ALU_ADD, 32'h0);
    tick();
    checkOutput("wd_r1", bus.WriteData, 32'd12);
    applyStimulus(0,1,0,0, 2'b00,2'b00,2'b01,2'b10,2'b00, ALU_ADD, 32'h0);
    checkOutput("ovf_result", bus.Adr, 32'h8000_0000);
    checkOutput("ovf_flags", {28'b0, bus.ALUFlags}, 32'h9);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0,1,0,0, 2'b00,2'b00,2'b01,2'b10,2'b00, opTab[i], 32'h0);
      checkOutput($sformatf("logic_op%0d_result", i), bus.Adr, resTab[i]);
      checkOutput($sformatf("logic_op%0d_flags", i), {28'b0, bus.ALUFlags}, {28'b0, flagTab[i]});
    end
    tick();

    // LDR R3,[R0,#0x10]
    applyStimulus(0,0,1,0, 2'b00,2'b11,2'b11,2'b00,2'b00, ALU_ADD, 32'hE590_3010);
    tick();
    applyStimulus(0,0,0,0, 2'b00,2'b11,2'b01,2'b10,2'b01, ALU_ADD, 32'h0);
    tick();
    applyStimulus(0,1,0,0, 2'b00,2'b11,2'b11,2'b00,2'b00, ALU_ADD, 32'hDEAD_BEEF);
    checkOutput("ldr_adr", bus.Adr, 32'h10);
    tick();
    applyStimulus(0,0,0,1, 2'b00,2'b11,2'b11,2'b01,2'b00, ALU_ADD, 32'h0);
    tick();
    applyStimulus(0,0,0,0, 2'b10,2'b11,2'b11,2'b00,2'b00, ALU_ADD, 32'h0);
    tick();
    checkOutput("ldr_rd", bus.WriteData, 32'hDEAD_BEEF);

    // Branch immediate extension
    applyStimulus(0,0,1,0, 2'b00,2'b11,2'b11,2'b00,2'b00, ALU_ADD, 32'hEAFF_FFFE);
    tick();
    applyStimulus(0,1,0,0, 2'b00,2'b11,2'b01,2'b10,2'b10, ALU_ADD, 32'h0);
    checkOutput("ext_imm24", bus.Adr, 32'hFFFF_FFF8);
    applyStimulus(0,1,0,0, 2'b00,2'b11,2'b01,2'b10,2'b11, ALU_ADD, 32'h0);
    checkOutput("ext_imm_zero", bus.Adr, 32'h0);
    tick();

    // Register write with Rd=15 must leave PC alone
    applyStimulus(0,0,1,0, 2'b00,2'b11,2'b11,2'b00,2'b00, ALU_ADD, 32'hE3A0_F0AA);
    tick();
    applyStimulus(0,0,0,1, 2'b00,2'b11,2'b01,2'b10,2'b00, ALU_ADD, 32'h0);
    checkOutput("rd15_pc_before", bus.Adr, 32'h4);
    tick();
    applyStimulus(0,0,0,0, 2'b00,2'b11,2'b11,2'b00,2'b00, ALU_ADD, 32'h0);
    checkOutput("rd15_pc_after", bus.Adr, 32'h4);

    // Asynchronous reset with live state, checked before any clock edge
    applyStimulus(0,1,0,0, 2'b00,2'b11,2'b11,2'b00,2'b00, ALU_ADD, 32'h0);
    checkOutput("pre_reset_aluout", bus.Adr, 32'hAA);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_aluout", bus.Adr, 32'h0);
    checkOutput("async_reset_instr", bus.Instr, 32'h0);
    applyStimulus(0,0,0,0, 2'b00,2'b11,2'b11,2'b00,2'b00, ALU_ADD, 32'h0);
    checkOutput("async_reset_pc", bus.Adr, 32'h0);
    tick();
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
